// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI arbiter: parameter defaults, FSM state
// encoding and a pointer-width helper.
package spi_arb_pkg;

    localparam int DEF_N_REQ      = 4;
    localparam int DEF_CMD_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TO_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    // A single requester still needs a 1-bit pointer so the vectors stay legal
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_select.sv
// Combinational round-robin picker: the first set request at or above the
// pointer wins, wrapping around to requester 0.
module rr_select #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx
);

    always_comb begin
        int   k;
        logic found;
        k       = 0;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(i_ptr) + i) % N_REQ;
            if (!found && i_req[k]) begin
                found      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = k[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between N_REQ requesters: round-robin grant, one
// start pulse per transaction, watchdog on the master's completion.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TO_WIDTH   = DEF_TO_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*CMD_WIDTH-1:0] i_cmd,
    output logic [N_REQ-1:0]           o_grant,
    output logic [N_REQ-1:0]           o_done,
    output logic [N_REQ-1:0]           o_err,
    output logic [DATA_WIDTH-1:0]      o_rdata,
    output logic                       o_start,
    output logic [CMD_WIDTH-1:0]       o_cmd,
    input  logic                       i_done,
    input  logic [DATA_WIDTH-1:0]      i_rdata
);

    localparam int PTR_W = ptrWidth(N_REQ);

    arb_state_t          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_gidx;
    logic [TO_WIDTH-1:0] r_wdog;

    logic [N_REQ-1:0]     w_grant;
    logic [PTR_W-1:0]     w_idx;
    logic [PTR_W-1:0]     w_ptrNext;
    logic [CMD_WIDTH-1:0] w_cmdSel;

    rr_select #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_ptrNext = (int'(r_gidx) == N_REQ - 1) ? '0 : r_gidx + 1'b1;
    assign w_cmdSel  = i_cmd[int'(w_idx)*CMD_WIDTH +: CMD_WIDTH];

    // Pulses default low each cycle; a completion beats a watchdog expiry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_wdog  <= '0;
            o_grant <= '0;
            o_done  <= '0;
            o_err   <= '0;
            o_start <= 1'b0;
            o_cmd   <= '0;
            o_rdata <= '0;
        end else begin
            o_start <= 1'b0;
            o_done  <= '0;
            o_err   <= '0;
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        o_grant <= w_grant;
                        r_gidx  <= w_idx;
                        o_cmd   <= w_cmdSel;
                        o_start <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_wdog  <= '0;
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_done) begin
                        o_rdata <= i_rdata;
                        o_done  <= o_grant;
                        r_state <= RELEASE;
                    end else if (&r_wdog) begin
                        o_err   <= o_grant;
                        r_state <= RELEASE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RELEASE: begin
                    o_grant <= '0;
                    r_ptr   <= w_ptrNext;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a table of single transactions plus
// hand-written fairness, watchdog, collision, stray-done and reset sequences.
module tb_spi_arbiter;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [3:0]  i_req;
    logic [31:0] i_cmd;
    logic [3:0]  o_grant;
    logic [3:0]  o_done;
    logic [3:0]  o_err;
    logic [15:0] o_rdata;
    logic        o_start;
    logic [7:0]  o_cmd;
    logic        i_done;
    logic [15:0] i_rdata;

    int testsRun    = 0;
    int testsFailed = 0;

    int startCount = 0;
    int gapErrors  = 0;
    logic prevStart = 1'b0;

    logic [3:0]  gotGrant, gotDone, gotErr, gotGrantAfter, gotPulseAfter;
    logic [7:0]  gotCmd;
    logic [15:0] gotRdata;
    logic        gotStartNow;
    int          gotLatency, gotCycles, gotStarts;

    typedef struct {
        logic [3:0]  req;
        int          doneDelay;
        logic [15:0] rdata;
        logic [3:0]  expGrant;
        logic [7:0]  expCmd;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] cmdTable[4];

    spi_arbiter dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_cmd   (i_cmd),
        .o_grant (o_grant),
        .o_done  (o_done),
        .o_err   (o_err),
        .o_rdata (o_rdata),
        .o_start (o_start),
        .o_cmd   (o_cmd),
        .i_done  (i_done),
        .i_rdata (i_rdata)
    );

    always #5 clk = ~clk;

    // Start pulses are tallied on the falling edge, away from the state updates
    always @(negedge clk) begin
        if (o_start) startCount++;
        if (o_start && prevStart) gapErrors++;
        prevStart = o_start;
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One full transaction starting from IDLE; a negative doneDelay never answers
    task automatic applyStimulus(input logic [3:0] req, input int doneDelay, input logic [15:0] rd, input bit dropReq);
        int startsBefore;
        int count;
        startsBefore  = startCount;
        gotGrant      = '0;
        gotCmd        = '0;
        gotDone       = '0;
        gotErr        = '0;
        gotRdata      = '0;
        gotStartNow   = 1'b0;
        gotGrantAfter = 'x;
        gotPulseAfter = 'x;
        gotCycles     = -1;
        i_req         = req;
        gotLatency    = 0;
        do begin
            stepCycle();
            gotLatency++;
        end while (o_grant == 4'b0 && gotLatency < 10);
        gotGrant    = o_grant;
        gotCmd      = o_cmd;
        gotStartNow = o_start;
        if (o_grant != 4'b0) begin
            stepCycle();
            i_rdata = rd;
            count   = 0;
            while (count < 400) begin
                if (count == doneDelay) i_done = 1'b1;
                stepCycle();
                i_done = 1'b0;
                count++;
                if (o_done != 4'b0 || o_err != 4'b0) break;
            end
            gotCycles = count;
            gotDone   = o_done;
            gotErr    = o_err;
            gotRdata  = o_rdata;
            if (dropReq) i_req = req & ~(o_done | o_err);
            stepCycle();
            gotGrantAfter = o_grant;
            gotPulseAfter = o_done | o_err;
        end
        gotStarts = startCount - startsBefore;
    endtask

    task automatic checkTxn(input string tag, input logic [3:0] expGrant, input logic [7:0] expCmd,
                            input logic [3:0] expDone, input logic [3:0] expErr,
                            input logic [15:0] expRdata, input int expCycles);
        checkOutput({tag, " grant"}, gotGrant, expGrant);
        checkOutput({tag, " cmd"}, gotCmd, expCmd);
        checkOutput({tag, " latency"}, gotLatency, 1);
        checkOutput({tag, " start"}, gotStartNow, 1'b1);
        checkOutput({tag, " starts"}, gotStarts, 1);
        checkOutput({tag, " done"}, gotDone, expDone);
        checkOutput({tag, " err"}, gotErr, expErr);
        checkOutput({tag, " rdata"}, gotRdata, expRdata);
        checkOutput({tag, " cycles"}, gotCycles, expCycles);
        checkOutput({tag, " released"}, gotGrantAfter, 4'b0);
        checkOutput({tag, " nopulse"}, gotPulseAfter, 4'b0);
    endtask

    task automatic applyReset();
        i_rst_n = 1'b0;
        stepCycle();
        stepCycle();
        i_rst_n = 1'b1;
    endtask

    initial begin
        int waitCount;
        cmdTable = '{8'h11, 8'h22, 8'hA5, 8'h44};
        vecs[0]  = '{4'b0100, 10, 16'h1234, 4'b0100, 8'hA5};
        vecs[1]  = '{4'b0011,  0, 16'hBEEF, 4'b0001, 8'h11};
        vecs[2]  = '{4'b1001,  3, 16'h0F0F, 4'b1000, 8'h44};
        vecs[3]  = '{4'b0010,  5, 16'hCAFE, 4'b0010, 8'h22};
        vecs[4]  = '{4'b1111,  1, 16'h5A5A, 4'b0100, 8'hA5};
        vecs[5]  = '{4'b0110,  2, 16'h0001, 4'b0010, 8'h22};

        i_rst_n = 1'b0;
        i_req   = '0;
        i_cmd   = {8'h44, 8'hA5, 8'h22, 8'h11};
        i_done  = 1'b0;
        i_rdata = '0;
        #2;
        checkOutput("reset outputs", {o_grant, o_done, o_err, o_start, o_cmd, o_rdata}, 64'd0);
        stepCycle();
        i_rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].req, vecs[v].doneDelay, vecs[v].rdata, 1'b1);
            checkTxn($sformatf("vec%0d", v), vecs[v].expGrant, vecs[v].expCmd,
                     vecs[v].expGrant, 4'b0, vecs[v].rdata, vecs[v].doneDelay + 1);
        end

        // Stray completion while idle must leave everything alone; pointer stays at 2
        i_req   = '0;
        i_rdata = 16'hFFFF;
        i_done  = 1'b1;
        stepCycle();
        stepCycle();
        i_done = 1'b0;
        checkOutput("stray rdata", o_rdata, 16'h0001);
        checkOutput("stray outputs", {o_grant, o_done, o_err, o_start}, 13'd0);
        applyStimulus(4'b1111, 0, 16'h7777, 1'b0);
        checkTxn("after stray", 4'b0100, 8'hA5, 4'b0100, 4'b0, 16'h7777, 1);

        applyReset();
        for (int t = 0; t < 8; t++) begin
            applyStimulus(4'b1111, 2, 16'h1000 + 16'(t), 1'b0);
            checkTxn($sformatf("fair%0d", t), 4'b0001 << (t % 4), cmdTable[t % 4],
                     4'b0001 << (t % 4), 4'b0, 16'h1000 + 16'(t), 3);
        end
        checkOutput("start gap", gapErrors, 0);

        applyStimulus(4'b0010, -1, 16'hDEAD, 1'b1);
        checkTxn("watchdog", 4'b0010, 8'h22, 4'b0, 4'b0010, 16'h1007, 256);
        applyStimulus(4'b1111, 0, 16'h2222, 1'b1);
        checkTxn("after watchdog", 4'b0100, 8'hA5, 4'b0100, 4'b0, 16'h2222, 1);

        applyStimulus(4'b0001, 255, 16'hC0DE, 1'b1);
        checkTxn("collision", 4'b0001, 8'h11, 4'b0001, 4'b0, 16'hC0DE, 256);

        // Abort mid-wait: outputs clear at once and no pulse follows the release
        i_req     = 4'b1000;
        waitCount = 0;
        do begin
            stepCycle();
            waitCount++;
        end while (o_grant == 4'b0 && waitCount < 10);
        checkOutput("abort grant", o_grant, 4'b1000);
        for (int c = 0; c < 5; c++) stepCycle();
        i_req   = '0;
        i_rst_n = 1'b0;
        #1;
        checkOutput("abort immediate", {o_grant, o_done, o_err, o_start, o_cmd, o_rdata}, 64'd0);
        stepCycle();
        stepCycle();
        i_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput($sformatf("abort quiet%0d", c), {o_grant, o_done, o_err, o_start}, 13'd0);
        end
        applyStimulus(4'b1111, 0, 16'h4242, 1'b1);
        checkTxn("after abort", 4'b0001, 8'h11, 4'b0001, 4'b0, 16'h4242, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one SPI master; legal range 1..8.
REQ-002 Parameter CMD_WIDTH, default 8: width of the command byte issued to the master.
REQ-003 Parameter DATA_WIDTH, default 16: width of the read word returned by the master.
REQ-004 Parameter TO_WIDTH, default 8: width of the transaction watchdog counter.
REQ-005 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port i_req, input, N_REQ: level request per requester, held high until that requester's o_done or o_err pulse.
REQ-008 Port i_cmd, input, N_REQ*CMD_WIDTH: flattened commands; requester k occupies bits [k*CMD_WIDTH +: CMD_WIDTH].
REQ-009 Port o_grant, output, N_REQ: one-hot grant, or all zero.
REQ-010 Port o_done, output, N_REQ: one-cycle pulse to the granted requester on completion.
REQ-011 Port o_err, output, N_REQ: one-cycle pulse to the granted requester on watchdog expiry.
REQ-012 Port o_rdata, output, DATA_WIDTH: last read word; valid while o_done is high.
REQ-013 Port o_start, output, 1: one-cycle start pulse to the master.
REQ-014 Port o_cmd, output, CMD_WIDTH: command to the master; stable from o_start until exit from WAIT_DONE.
REQ-015 Port i_done, input, 1: master completion pulse.
REQ-016 Port i_rdata, input, DATA_WIDTH: master read word; valid in the i_done cycle.

Function
REQ-017 The FSM SHALL have four states: IDLE, START, WAIT_DONE, RELEASE.
REQ-018 IDLE: when any i_req bit is high, the block SHALL on the next edge select the requester by round-robin starting at pointer ptr, set o_grant one-hot, latch that requester's command into o_cmd, and enter START.
REQ-019 START: o_start SHALL be high for exactly this one cycle; next state is WAIT_DONE with the watchdog cleared to 0.
REQ-020 WAIT_DONE: on i_done, the block SHALL latch i_rdata into o_rdata, pulse o_done[g] in the following cycle, and enter RELEASE.
REQ-021 WAIT_DONE: the watchdog SHALL increment every cycle without i_done; at all-ones without i_done, the block SHALL pulse o_err[g] in the following cycle and enter RELEASE.
REQ-022 If i_done and watchdog expiry occur in the same cycle, done SHALL win and o_err SHALL stay low.
REQ-023 RELEASE, one cycle: o_grant SHALL go to zero, ptr SHALL become (g+1) mod N_REQ, and next state is IDLE; this guarantees at least one idle cycle between o_start pulses.
REQ-024 Round-robin: the first set bit at or above ptr is chosen, wrapping to 0; requester ptr has highest priority.
REQ-025 Latency: i_req high in IDLE -> o_grant at edge +1 -> o_start at edge +1 to +2 (it occupies the START cycle).
REQ-026 A granted requester dropping i_req mid-transaction SHALL NOT abort the transaction; the done/err pulse is still issued.
REQ-027 i_done outside WAIT_DONE SHALL be ignored, with no state change and no o_rdata update.
REQ-028 o_rdata SHALL hold its value between transactions and SHALL NOT change on an err exit.
REQ-029 With N_REQ=1, ptr SHALL remain 0 and operation SHALL be otherwise identical.

Reset
REQ-030 On i_rst_n low, asynchronously: state=IDLE, ptr=0, watchdog=0, and o_grant, o_done, o_err, o_start, o_cmd, o_rdata all zero.
REQ-031 Reset asserted mid-transaction SHALL abort silently, with no done or err pulse after release.
REQ-032 First grant after reset release SHALL be no earlier than the first rising edge with i_rst_n high.

Structure
REQ-033 Package spi_arb_pkg SHALL hold the state encoding constants and the default values of N_REQ, CMD_WIDTH, DATA_WIDTH and TO_WIDTH.
REQ-034 The round-robin selector SHALL be one combinational sub-module rr_select (inputs req and ptr; outputs one-hot grant and index); all other logic stays in spi_arbiter.

Verification
REQ-035 Single request: i_req=4'b0100, cmd2=8'hA5, i_done after 10 cycles with i_rdata=16'h1234 -> o_grant=4'b0100, o_cmd=8'hA5, exactly one o_start, o_done=4'b0100 with o_rdata=16'h1234.
REQ-036 Fairness: i_req=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with at least one o_start-free cycle between o_start pulses.
REQ-037 Watchdog: no i_done after o_start -> o_err pulse exactly 2^TO_WIDTH cycles after entering WAIT_DONE, o_rdata unchanged, next grant to ptr+1.
REQ-038 Collision: i_done on the watchdog all-ones cycle -> o_done pulses, o_err stays 0.
REQ-039 Reset mid-WAIT_DONE: i_rst_n low for 2 cycles -> all outputs 0 immediately, no done or err pulse, next grant from requester 0.
REQ-040 Stray i_done while in IDLE with i_rdata=16'hFFFF -> o_rdata, state and outputs unchanged.
